dma_cfg_icb_master: RTL

//  ICB initiator that programs the DMA config slave and polls it to completion.
//  On start, snapshots a descriptor and issues single-outstanding writes: CTR, SRC, DST, LEN, then CR with the start bit.

---
 rtl/dma_cfg_pkg.sv | 39 +++
 rtl/dma_cfg_icb_master_if.sv | 25 ++
 rtl/dma_cfg_icb_xfer.sv | 72 +++++++
 rtl/dma_cfg_icb_master.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dma_cfg_pkg.sv
// rtl/dma_cfg_pkg.sv - register map, bit positions and state types for the DMA config ICB master
package dma_cfg_pkg;

   localparam logic [7:0] OFF_SR  = 8'h00;
   localparam logic [7:0] OFF_CTR = 8'h04;
   localparam logic [7:0] OFF_CR  = 8'h08;
   localparam logic [7:0] OFF_SRC = 8'h0C;
   localparam logic [7:0] OFF_DST = 8'h10;
   localparam logic [7:0] OFF_LEN = 8'h14;

   // CR start bit self-clears in the slave, so it is set on every CR write
   localparam int CR_START_BIT = 7;
   localparam int SR_DONE_BIT  = 1;
   localparam int SR_BUSY_BIT  = 2;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_W_CTR,
      ST_W_SRC,
      ST_W_DST,
      ST_W_LEN,
      ST_W_CR,
      ST_R_SR,
      ST_GAP,
      ST_FIN
   } state_t;

   typedef enum logic [1:0] {
      XF_IDLE,
      XF_CMD,
      XF_RSP
   } xfer_state_t;

   // 32-bit sum wraps silently
   function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [7:0] off);
      return base + {24'h0, off};
   endfunction

endpackage

// File: rtl/dma_cfg_icb_master_if.sv
// rtl/dma_cfg_icb_master_if.sv - ICB command/response bundle between the config master and the DMA slave
interface dma_cfg_icb_master_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_read;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wmask;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dma_cfg_icb_xfer.sv
// rtl/dma_cfg_icb_xfer.sv - single-outstanding ICB access engine: one request becomes CMD then RSP phase
module dma_cfg_icb_xfer (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        read,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        abort,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        rsp_err,
   output logic        rsp_phase,
   dma_cfg_icb_master_if.master icb
);
   import dma_cfg_pkg::*;

   xfer_state_t xs;

   assign rsp_phase = (xs == XF_RSP);

   always_ff @(posedge clk) begin
      if (rst) begin
         xs            <= XF_IDLE;
         icb.cmd_valid <= 1'b0;
         icb.cmd_read  <= 1'b0;
         icb.cmd_addr  <= '0;
         icb.cmd_wdata <= '0;
         icb.cmd_wmask <= '0;
         icb.rsp_ready <= 1'b0;
         ack           <= 1'b0;
         rdata         <= '0;
         rsp_err       <= 1'b0;
      end else begin
         ack <= 1'b0;
         case (xs)
            XF_IDLE: begin
               if (req && !abort) begin
                  icb.cmd_valid <= 1'b1;
                  icb.cmd_read  <= read;
                  icb.cmd_addr  <= addr;
                  icb.cmd_wdata <= read ? 32'h0 : wdata;
                  icb.cmd_wmask <= read ? 4'h0 : 4'hF;
                  xs            <= XF_CMD;
               end
            end
            XF_CMD: begin
               // abort only ever comes from the poll timeout; otherwise hold until accepted
               if (abort) begin
                  icb.cmd_valid <= 1'b0;
                  xs            <= XF_IDLE;
               end else if (icb.cmd_ready) begin
                  icb.cmd_valid <= 1'b0;
                  icb.rsp_ready <= 1'b1;
                  xs            <= XF_RSP;
               end
            end
            XF_RSP: begin
               if (icb.rsp_valid) begin
                  icb.rsp_ready <= 1'b0;
                  ack           <= 1'b1;
                  rdata         <= icb.rsp_rdata;
                  rsp_err       <= icb.rsp_err;
                  xs            <= XF_IDLE;
               end
            end
            default: xs <= XF_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/dma_cfg_icb_master.sv
// rtl/dma_cfg_icb_master.sv - programs the DMA config slave and polls SR; DMA_CFG_TIMEOUT_EN adds a poll budget
module dma_cfg_icb_master #(
   parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
   parameter int          POLL_GAP       = 8,
   parameter int          TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  desc_ctr,
   input  logic [7:0]  desc_cr,
   input  logic [31:0] desc_src,
   input  logic [31:0] desc_dst,
   input  logic [31:0] desc_len,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] sr_last,
   dma_cfg_icb_master_if.master icb
);
   import dma_cfg_pkg::*;

   state_t      state;
   logic [7:0]  snap_ctr;
   logic [7:0]  snap_cr;
   logic [31:0] snap_src;
   logic [31:0] snap_dst;
   logic [31:0] snap_len;
   logic [15:0] gap_cnt;

   logic        req;
   logic        x_read;
   logic [7:0]  x_off;
   logic [31:0] x_addr;
   logic [31:0] x_wdata;
   logic        x_ack;
   logic [31:0] x_rdata;
   logic        x_err;
   logic        x_rsp_phase;
   logic        x_abort;
   logic        to_hit;
   logic [7:0]  cr_w;

   // access parameters follow the current state; the engine samples them when req is high
   always_comb begin
      x_off   = OFF_SR;
      x_wdata = '0;
      cr_w    = snap_cr;
      cr_w[CR_START_BIT] = 1'b1;
      case (state)
         ST_W_CTR: begin x_off = OFF_CTR; x_wdata = {24'h0, snap_ctr}; end
         ST_W_SRC: begin x_off = OFF_SRC; x_wdata = snap_src; end
         ST_W_DST: begin x_off = OFF_DST; x_wdata = snap_dst; end
         ST_W_LEN: begin x_off = OFF_LEN; x_wdata = snap_len; end
         ST_W_CR:  begin x_off = OFF_CR;  x_wdata = {24'h0, cr_w}; end
         default:  begin x_off = OFF_SR;  x_wdata = '0; end
      endcase
   end

   assign x_read  = (state == ST_R_SR);
   assign x_addr  = reg_addr(BASE_ADDR, x_off);
   assign x_abort = (state == ST_R_SR) && to_hit && !x_rsp_phase && !x_ack;

`ifdef DMA_CFG_TIMEOUT_EN
   logic [31:0] to_cnt;

   // budget covers the whole polling phase, not individual polls
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt <= '0;
      end else if (state == ST_W_CR && x_ack && !x_err) begin
         to_cnt <= '0;
      end else if ((state == ST_R_SR || state == ST_GAP) && !to_hit) begin
         to_cnt <= to_cnt + 32'd1;
      end
   end

   assign to_hit = (to_cnt >= 32'(TIMEOUT_CYCLES));
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         sr_last  <= '0;
         snap_ctr <= '0;
         snap_cr  <= '0;
         snap_src <= '0;
         snap_dst <= '0;
         snap_len <= '0;
         gap_cnt  <= '0;
         req      <= 1'b0;
      end else begin
         req  <= 1'b0;
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  snap_ctr <= desc_ctr;
                  snap_cr  <= desc_cr;
                  snap_src <= desc_src;
                  snap_dst <= desc_dst;
                  snap_len <= desc_len;
                  err      <= 1'b0;
                  busy     <= 1'b1;
                  req      <= 1'b1;
                  state    <= ST_W_CTR;
               end
            end
            ST_W_CTR, ST_W_SRC, ST_W_DST, ST_W_LEN, ST_W_CR: begin
               if (x_ack) begin
                  if (x_err) begin
                     err   <= 1'b1;
                     state <= ST_FIN;
                  end else begin
                     req <= 1'b1;
                     case (state)
                        ST_W_CTR: state <= ST_W_SRC;
                        ST_W_SRC: state <= ST_W_DST;
                        ST_W_DST: state <= ST_W_LEN;
                        ST_W_LEN: state <= ST_W_CR;
                        default:  state <= ST_R_SR;
                     endcase
                  end
               end
            end
            ST_R_SR: begin
               if (x_ack) begin
                  sr_last <= x_rdata;
                  if (x_rdata[SR_DONE_BIT]) begin
                     state <= ST_FIN;
                  end else if (x_err || to_hit) begin
                     err   <= 1'b1;
                     state <= ST_FIN;
                  end else if (POLL_GAP == 0) begin
                     req <= 1'b1;
                  end else begin
                     gap_cnt <= '0;
                     state   <= ST_GAP;
                  end
               end else if (to_hit && !x_rsp_phase) begin
                  err   <= 1'b1;
                  state <= ST_FIN;
               end
            end
            ST_GAP: begin
               if (to_hit) begin
                  err   <= 1'b1;
                  state <= ST_FIN;
               end else if (gap_cnt == 16'(POLL_GAP - 1)) begin
                  req   <= 1'b1;
                  state <= ST_R_SR;
               end else begin
                  gap_cnt <= gap_cnt + 16'd1;
               end
            end
            ST_FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   dma_cfg_icb_xfer u_xfer (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .read      (x_read),
      .addr      (x_addr),
      .wdata     (x_wdata),
      .abort     (x_abort),
      .ack       (x_ack),
      .rdata     (x_rdata),
      .rsp_err   (x_err),
      .rsp_phase (x_rsp_phase),
      .icb       (icb)
   );

endmodule
